// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_arb_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef logic req_id_t;

  function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to prio.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one data memory between two requesters.
// Optional alignment checking is enabled by defining DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter #(
  parameter int unsigned AW = dmem_arb_pkg::AW,
  parameter int unsigned DW = dmem_arb_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [1:0]    req_we,
  input  logic [AW-1:0] req_addr  [2],
  input  logic [DW-1:0] req_wdata [2],
  output logic [1:0]    rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [1:0]    rsp_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_r,
  output logic          mem_w,
  input  logic [DW-1:0] mem_rdata
);

  import dmem_arb_pkg::*;

  state_t        state_q, state_d;
  req_id_t       owner_q, owner_d;
  logic          prio_q, prio_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [1:0]    grant;
  req_id_t       win_id;
  logic          accept;
  logic          misalign;
  logic          issue;

  rr_arbiter2 u_rr (
    .req   (req_valid),
    .prio  (prio_q),
    .grant (grant)
  );

  assign win_id    = grant[1];
  assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
  assign accept    = |req_ready;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign misalign  = |req_addr[win_id][1:0];
`else
  assign misalign  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          owner_d = win_id;
          prio_d  = ~win_id;
          we_d    = req_we[win_id];
          err_d   = misalign;
          addr_d  = req_addr[win_id];
          wdata_d = req_wdata[win_id];
        end
      end
      ISSUE: begin
        state_d = RESP;
        // Writes and rejected accesses report zero data.
        rdata_d = (we_q || err_q) ? '0 : mem_rdata;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign issue     = (state_q == ISSUE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_r     = issue && !we_q && !err_q;
  assign mem_w     = issue &&  we_q && !err_q;
  assign rsp_valid = (state_q == RESP) ? id_onehot(owner_q) : '0;
  assign rsp_rdata = rdata_q;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign rsp_err   = (state_q == RESP && err_q) ? id_onehot(owner_q) : '0;
`else
  assign rsp_err   = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a byte-array memory model and a
// transaction-level reference model for randomized traffic.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_r, mem_w;

  logic [7:0]  mem [4096];
  logic [11:0] ma;
  logic [31:0] ref_words [logic [11:0]];

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_r     (mem_r),
    .mem_w     (mem_w),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int unsigned i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  function automatic logic [31:0] word_at(input int unsigned a);
    return {mem[(a + 3) % 4096], mem[(a + 2) % 4096], mem[(a + 1) % 4096], mem[a % 4096]};
  endfunction

  // Memory model: 4 KiB byte array, little-endian, wraps at the boundary.
  assign ma        = mem_addr[11:0];
  assign mem_rdata = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};

  always @(posedge clk) begin
    if (mem_w) begin
      for (int i = 0; i < 4; i++) mem[ma + 12'(i)] <= mem_wdata[8*i +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_we = '0;
    req_addr[0] = '0;  req_addr[1] = '0;
    req_wdata[0] = '0; req_wdata[1] = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    checks++; if (rsp_err !== 2'b00) begin errors++; $display("FAIL reset_rsp_err: got %b expected 00", rsp_err); end
    checks++; if ({mem_r, mem_w} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {mem_r, mem_w}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || mem_r !== 1'b0 || mem_w !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet: got ready=%b rsp=%b r=%b w=%b expected all 0", req_ready, rsp_valid, mem_r, mem_w);
      end
    end
  endtask

  task automatic test_write_read();
    tick();
    req_valid = 2'b01; req_we = 2'b01;
    req_addr[0] = 32'h010; req_wdata[0] = 32'hDEADBEEF;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if ({mem_r, mem_w} !== 2'b01) begin errors++; $display("FAIL wr_strobes: got r/w=%b expected 01", {mem_r, mem_w}); end
    checks++; if (mem_addr !== 32'h010 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_bus: got %h/%h expected 00000010/deadbeef", mem_addr, mem_wdata); end
    tick();
    #1;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL wr_rsp_valid: got %b expected 01", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp_rdata: got %h expected 0", rsp_rdata); end
    tick();
    req_valid = 2'b01; req_we = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_rsp_once: got %b expected 00", rsp_valid); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rd_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if ({mem_r, mem_w} !== 2'b10) begin errors++; $display("FAIL rd_strobes: got r/w=%b expected 10", {mem_r, mem_w}); end
    tick();
    #1;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rd_rsp_valid: got %b expected 01", rsp_valid); end
    checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rsp_rdata: got %h expected deadbeef", rsp_rdata); end
    tick();
  endtask

  task automatic test_alternate();
    int n;
    int last;
    logic [1:0] exp;
    n = 0;
    last = -100;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 2'b11; req_we = 2'b00;
    req_addr[0] = 32'h000; req_addr[1] = 32'h004;
    for (int c = 0; c < 30 && n < 4; c++) begin
      #1;
      checks++; if (req_ready === 2'b11) begin errors++; $display("FAIL alt_two_hot: got %b expected at most one bit", req_ready); end
      if (req_ready !== 2'b00) begin
        exp = (n % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (req_ready !== exp) begin errors++; $display("FAIL alt_grant: got %b expected %b", req_ready, exp); end
        if (n > 0) begin
          checks++; if (c - last != 3) begin errors++; $display("FAIL alt_spacing: got %0d expected 3", c - last); end
        end
        last = c;
        n++;
      end
      tick();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL alt_timeout: got %0d accepts expected 4", n); end
    req_valid = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    int last;
    int wcount;
    n = 0;
    last = -100;
    wcount = 0;
    req_valid = 2'b10; req_we = 2'b10;
    req_addr[1] = 32'h100; req_wdata[1] = 32'hA5A50000;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (mem_w) begin
        wcount++;
        checks++; if (c != last + 1) begin errors++; $display("FAIL b2b_w_slot: got cycle %0d expected %0d", c, last + 1); end
      end
      if (req_ready !== 2'b00) begin
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL b2b_ready: got %b expected 10", req_ready); end
        if (n > 0) begin
          checks++; if (c - last != 3) begin errors++; $display("FAIL b2b_spacing: got %0d expected 3", c - last); end
        end
        last = c;
        n++;
      end
      tick();
      if (n >= 3) req_valid = 2'b00;
      else begin
        req_addr[1] = 32'h100 + 32'(4 * n);
        req_wdata[1] = 32'hA5A50000 + 32'(n);
      end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", n); end
    checks++; if (wcount != 3) begin errors++; $display("FAIL b2b_wcount: got %0d expected 3", wcount); end
    checks++; if (word_at(32'h104) !== 32'hA5A50001) begin errors++; $display("FAIL b2b_mem: got %h expected a5a50001", word_at(32'h104)); end
  endtask

  task automatic test_reset_in_resp();
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 32'h010;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    #1;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rr_pre_rsp: got %b expected 01", rsp_valid); end
    rst = 1'b1;
    tick();
    #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rr_rsp_killed: got %b expected 00", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rr_rdata_cleared: got %h expected 0", rsp_rdata); end
    rst = 1'b0;
    req_valid = 2'b11;
    req_addr[0] = 32'h000; req_addr[1] = 32'h004;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_idle_prio0: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_align();
    logic [31:0] exp_data;
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 32'h013;
    exp_data = word_at(32'h013);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL al_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (mem_r !== !ALIGN || mem_w !== 1'b0) begin errors++; $display("FAIL al_strobes: got r=%b w=%b expected r=%b w=0", mem_r, mem_w, !ALIGN); end
    tick();
    #1;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL al_rsp_valid: got %b expected 01", rsp_valid); end
    checks++; if (rsp_err !== (ALIGN ? 2'b01 : 2'b00)) begin errors++; $display("FAIL al_rsp_err: got %b expected %b", rsp_err, ALIGN ? 2'b01 : 2'b00); end
    checks++; if (rsp_rdata !== (ALIGN ? 32'h0 : exp_data)) begin errors++; $display("FAIL al_rsp_rdata: got %h expected %h", rsp_rdata, ALIGN ? 32'h0 : exp_data); end
    tick();
  endtask

  task automatic test_random();
    logic [1:0]  pend, exp_ready;
    logic        pwe [2];
    logic [31:0] paddr [2];
    logic [31:0] pdata [2];
    logic        ptr, cur_owner, cur_we;
    logic [31:0] cur_addr, cur_data, cur_exp;
    logic [11:0] key;
    int          phase;
    pend = '0; ptr = 1'b0; phase = 0;
    cur_owner = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_data = '0; cur_exp = '0;
    for (int r = 0; r < 2; r++) begin pwe[r] = 1'b0; paddr[r] = '0; pdata[r] = '0; end
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r]  = 1'b1;
          pwe[r]   = 1'($urandom_range(0, 1));
          paddr[r] = ($urandom & 32'hFFFFF000) | (32'h800 + 32'(4 * $urandom_range(0, 15)));
          pdata[r] = $urandom;
        end
        req_addr[r]  = paddr[r];
        req_wdata[r] = pdata[r];
      end
      req_valid = pend;
      req_we    = {pwe[1], pwe[0]};
      #1;
      case (pend)
        2'b01:   exp_ready = 2'b01;
        2'b10:   exp_ready = 2'b10;
        2'b11:   exp_ready = ptr ? 2'b10 : 2'b01;
        default: exp_ready = 2'b00;
      endcase
      if (phase != 0) exp_ready = 2'b00;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready: cycle %0d got %b expected %b", c, req_ready, exp_ready); end
      if (phase == 1) begin
        checks++;
        if (mem_w !== cur_we || mem_r !== !cur_we || mem_addr !== cur_addr || (cur_we && mem_wdata !== cur_data)) begin
          errors++;
          $display("FAIL rnd_issue: cycle %0d got r=%b w=%b a=%h d=%h expected we=%b a=%h d=%h", c, mem_r, mem_w, mem_addr, mem_wdata, cur_we, cur_addr, cur_data);
        end
      end else if (phase == 2) begin
        checks++;
        if (rsp_valid !== (cur_owner ? 2'b10 : 2'b01) || rsp_rdata !== cur_exp || rsp_err !== 2'b00) begin
          errors++;
          $display("FAIL rnd_resp: cycle %0d got v=%b d=%h e=%b expected owner=%0d d=%h", c, rsp_valid, rsp_rdata, rsp_err, cur_owner, cur_exp);
        end
      end else begin
        checks++;
        if (rsp_valid !== 2'b00 || mem_r !== 1'b0 || mem_w !== 1'b0) begin
          errors++;
          $display("FAIL rnd_idle: cycle %0d got v=%b r=%b w=%b expected 0", c, rsp_valid, mem_r, mem_w);
        end
      end
      if (phase == 0 && exp_ready != 2'b00) begin
        cur_owner = exp_ready[1];
        cur_we    = pwe[cur_owner];
        cur_addr  = paddr[cur_owner];
        cur_data  = pdata[cur_owner];
        key       = cur_addr[11:0];
        if (cur_we) begin
          ref_words[key] = cur_data;
          cur_exp = 32'h0;
        end else if (ref_words.exists(key)) begin
          cur_exp = ref_words[key];
        end else begin
          cur_exp = {init_byte(32'(key) + 3), init_byte(32'(key) + 2), init_byte(32'(key) + 1), init_byte(32'(key))};
        end
        ptr = ~cur_owner;
        pend[cur_owner] = 1'b0;
        phase = 1;
      end else if (phase == 1) begin
        phase = 2;
      end else begin
        phase = 0;
      end
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = init_byte(32'(i));
    test_reset();
    test_write_read();
    test_alternate();
    test_back_to_back();
    test_reset_in_resp();
    test_align();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port byte-addressed data memory. It shares the memory between the core load/store path (requester 0) and the program/data loader (requester 1). Arbitration is round-robin, and one access is in flight at a time. The block drives the memory's address, write-data and read/write strobes, captures read data into a register, and returns a one-cycle response pulse to the owning requester.

## Interface
Parameters:
- AW, 32, address width (memory decodes the low 12 bits).
- DW, 32, data width (little-endian word of 4 bytes).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; at most one bit high.
- req_we  in  2  per-requester: 1 = write, 0 = read.
- req_addr  in  2×AW  per-requester byte address (unpacked array [2]).
- req_wdata  in  2×DW  per-requester write data.
- rsp_valid  out  2  one-cycle completion pulse to the owner.
- rsp_rdata  out  DW  read data, qualified by rsp_valid.
- rsp_err  out  2  alignment error, qualified by rsp_valid.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_r  out  1  memory read strobe.
- mem_w  out  1  memory write strobe.
- mem_rdata  in  DW  memory read data.

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- Arbitration in IDLE:
  - Grant is combinational from req_valid and the priority pointer prio.
  - prio resets to 0, so requester 0 is favoured first.
  - If only one requester is valid, it wins. If both are valid, requester prio wins.
  - req_ready[g] = (state==IDLE) && req_valid[g] for the winner g only.
- Handshake:
  - An access is accepted when req_valid[g] && req_ready[g] at a posedge.
  - On acceptance, the block latches owner=g and latches addr, wdata and we into internal registers.
  - It sets prio = ~g and moves to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_addr and mem_wdata come from the latched registers.
  - mem_r = ~we. mem_w = we.
  - For a read, mem_rdata is registered into rsp_rdata at the posedge leaving ISSUE. For a write, the memory commits at that same posedge.
- RESP (exactly 1 cycle):
  - rsp_valid[owner] = 1.
  - rsp_rdata holds the captured word for reads and 0 for writes.
  - Next state is IDLE.
- Requests are not accepted in ISSUE or RESP; requesters must hold req_valid and their payload until req_ready.
- When not in ISSUE, mem_r = mem_w = 0. mem_addr and mem_wdata hold their last values.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_r=0, mem_w=0, mem_addr=0, mem_wdata=0, prio=0, owner=0.
- rst in ISSUE:
  - mem_w is decoded from state, so a write in ISSUE on the cycle rst is sampled still commits at that edge.
  - The response is discarded, and the state is IDLE after the edge.
- rst in RESP: no rsp_valid after the edge.
- Address wrap at the 4 KiB boundary (addr+1..+3) is the memory's behaviour. The arbiter passes the address unmodified.

## Timing
- Accept edge N → ISSUE during cycle N+1 → rsp_valid during cycle N+2 → IDLE at N+3.
- Throughput is one access per 3 cycles.
- Worst-case wait for a continuously valid requester is one competing access (3 cycles).
- req_ready depends combinationally on req_valid. All other outputs are registered or decoded from registered state only.

## Configuration
- `DMEM_ARB_ALIGN_CHECK_EN`
  - Defined: an accepted access with addr[1:0]!=0 still passes through ISSUE, but mem_r and mem_w stay 0 (no memory access). RESP pulses rsp_valid[owner] with rsp_err[owner]=1 and rsp_rdata=0.
  - Undefined: rsp_err is tied to 0, and misaligned addresses are passed to memory unchanged.

## Structure
- Package `dmem_arb_pkg`:
  - state enum (IDLE, ISSUE, RESP).
  - requester-id typedef (1 bit).
  - constants NUM_REQ=2, AW, DW.
- Sub-module `rr_arbiter2`:
  - inputs: req[1:0], prio.
  - output: one-hot grant[1:0].
  - purely combinational; the prio update lives in dmem_arbiter.

## Test plan
- Reset, then idle: all outputs 0, and req_ready stays 0 with no req_valid.
- Req0 write 0xDEADBEEF to 0x010, then req0 read 0x010:
  - the write produces rsp_valid[0] 2 cycles after its accept;
  - the read returns rsp_rdata=0xDEADBEEF with rsp_valid[0]=1 2 cycles after its accept.
- Both requesters valid continuously (reads of 0x000 and 0x004) from reset: grants alternate 0,1,0,1, accepts are spaced 3 cycles apart, and req_ready is never two-hot.
- Req1 alone issues 3 back-to-back writes: accepted on cycles N, N+3, N+6, and mem_w is high exactly one cycle each.
- rst asserted during RESP of a read: rsp_valid stays 0 after the reset edge, the state is IDLE, and prio=0.
- With `DMEM_ARB_ALIGN_CHECK_EN`, req0 read at 0x013: mem_r never rises, and rsp_valid[0]=1 with rsp_err[0]=1 and rsp_rdata=0. Without the macro, mem_r pulses and rsp_err=0.
